// File: rtl/dmadd_sequencer.sv
// Purpose: sequences one engine job per host command: clear, init, beat loads, timed run, result capture.
// Latency: first beat ready 3 cycles after cmd_valid in IDLE; result valid RUN_CYCLES+2 cycles after the last load cycle.
// Backpressure: cmd_ready only in LOAD; res_valid holds with stable data until res_ready, no new job until then.
module dmadd_sequencer #(
   parameter int RUN_CYCLES = 18
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        cmd_valid,
   output logic        cmd_ready,
   input  logic [1:0]  cmd_mode,
   input  logic [3:0]  cmd_index,
   input  logic [3:0]  cmd_data,
   input  logic        cmd_last,
   output logic        dm_rst_n,
   output logic        dm_run,
   output logic        dm_load,
   output logic [1:0]  dm_insn,
   output logic [3:0]  dm_index,
   output logic [3:0]  dm_data,
   input  logic [11:0] dm_out,
   output logic        res_valid,
   input  logic        res_ready,
   output logic [11:0] res_data,
   output logic        res_err,
   output logic        busy
);

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      CLEAR   = 3'd1,
      INIT    = 3'd2,
      LOAD    = 3'd3,
      RUN     = 3'd4,
      CAPTURE = 3'd5,
      RESULT  = 3'd6
   } state_t;

   localparam logic [1:0] MODE_MIN  = 2'b00;
   localparam logic [1:0] MODE_BAD  = 2'b11;
   localparam logic [7:0] RUN_LOAD  = 8'(RUN_CYCLES);

   state_t      state_q, state_d;
   logic [1:0]  mode_q, mode_d;
   logic        err_q, err_d;
   logic [7:0]  cnt_q, cnt_d;

   logic        dm_rst_n_d, dm_run_d, dm_load_d;
   logic [1:0]  dm_insn_d;
   logic [3:0]  dm_index_d, dm_data_d;
   logic        res_valid_d, res_err_d;
   logic [11:0] res_data_d;
   logic        accept;

   // Non-load engine cycles use 00 for MIN and 01 for MAX/MADD.
   function automatic logic [1:0] idle_insn(input logic [1:0] m);
      return (m == MODE_MIN) ? 2'b00 : 2'b01;
   endfunction

   assign cmd_ready = (state_q == LOAD);
   assign busy      = (state_q != IDLE);
   assign accept    = cmd_valid & cmd_ready;

   // Next state plus next value of every registered engine/result output.
   always_comb begin
      state_d     = state_q;
      mode_d      = mode_q;
      err_d       = err_q;
      cnt_d       = cnt_q;
      dm_rst_n_d  = 1'b1;
      dm_run_d    = 1'b0;
      dm_load_d   = 1'b0;
      dm_insn_d   = idle_insn(mode_q);
      dm_index_d  = dm_index;
      dm_data_d   = dm_data;
      res_valid_d = 1'b0;
      res_data_d  = res_data;
      res_err_d   = res_err;
      case (state_q)
         IDLE: begin
            if (cmd_valid) begin
               // Beat is only peeked here; it is consumed later in LOAD.
               state_d    = CLEAR;
               err_d      = (cmd_mode == MODE_BAD);
               mode_d     = (cmd_mode == MODE_BAD) ? MODE_MIN : cmd_mode;
               dm_rst_n_d = 1'b0;
               dm_insn_d  = idle_insn(mode_d);
            end
         end
         CLEAR: state_d = INIT;
         INIT:  state_d = LOAD;
         LOAD: begin
            if (accept) begin
               dm_load_d  = 1'b1;
               dm_insn_d  = mode_q;
               dm_index_d = cmd_index;
               dm_data_d  = cmd_data;
               if (cmd_last) begin
                  state_d = RUN;
                  cnt_d   = RUN_LOAD;
               end
            end
         end
         RUN: begin
            // The final load pulse occupies the first RUN cycle, so dm_run trails by one.
            if (cnt_q != 8'd0) begin
               dm_run_d  = 1'b1;
               dm_insn_d = mode_q;
               cnt_d     = cnt_q - 8'd1;
            end else begin
               state_d = CAPTURE;
            end
         end
         CAPTURE: begin
            res_valid_d = 1'b1;
            res_data_d  = dm_out;
            res_err_d   = err_q;
            state_d     = RESULT;
         end
         RESULT: begin
            if (res_ready) state_d = IDLE;
            else           res_valid_d = 1'b1;
         end
         default: state_d = IDLE;
      endcase
   end

   // State, job context and registered outputs; reset parks the engine in reset.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= IDLE;
         mode_q    <= MODE_MIN;
         err_q     <= 1'b0;
         cnt_q     <= 8'd0;
         dm_rst_n  <= 1'b0;
         dm_run    <= 1'b0;
         dm_load   <= 1'b0;
         dm_insn   <= 2'b00;
         dm_index  <= 4'd0;
         dm_data   <= 4'd0;
         res_valid <= 1'b0;
         res_data  <= 12'd0;
         res_err   <= 1'b0;
      end else begin
         state_q   <= state_d;
         mode_q    <= mode_d;
         err_q     <= err_d;
         cnt_q     <= cnt_d;
         dm_rst_n  <= dm_rst_n_d;
         dm_run    <= dm_run_d;
         dm_load   <= dm_load_d;
         dm_insn   <= dm_insn_d;
         dm_index  <= dm_index_d;
         dm_data   <= dm_data_d;
         res_valid <= res_valid_d;
         res_data  <= res_data_d;
         res_err   <= res_err_d;
      end
   end

endmodule

// File: tb/tb_dmadd_sequencer.sv
// Purpose: randomized job stimulus against a cycle-timeline model built from the job schedule.
// Latency: every output is compared once per cycle over each job window.
// Backpressure: res_ready is held off for a chosen number of RESULT cycles per job.
module tb_dmadd_sequencer;

   localparam int R = 18;
   localparam int N = 8192;

   logic        clk = 1'b0;
   logic        rst;
   logic        cmd_valid, cmd_ready, cmd_last;
   logic [1:0]  cmd_mode;
   logic [3:0]  cmd_index, cmd_data;
   logic        dm_rst_n, dm_run, dm_load;
   logic [1:0]  dm_insn;
   logic [3:0]  dm_index, dm_data;
   logic [11:0] dm_out;
   logic        res_valid, res_ready, res_err, busy;
   logic [11:0] res_data;

   int checks = 0;
   int failures = 0;
   int cyc = 0;

   logic [28:0] obs [N];
   logic [11:0] drv_out [N];
   logic [28:0] live;

   dmadd_sequencer #(.RUN_CYCLES(R)) dut (
      .clk(clk), .rst(rst),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_mode(cmd_mode),
      .cmd_index(cmd_index), .cmd_data(cmd_data), .cmd_last(cmd_last),
      .dm_rst_n(dm_rst_n), .dm_run(dm_run), .dm_load(dm_load), .dm_insn(dm_insn),
      .dm_index(dm_index), .dm_data(dm_data), .dm_out(dm_out),
      .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
      .res_err(res_err), .busy(busy)
   );

   always #5 clk = ~clk;

   assign live = {cmd_ready, dm_rst_n, dm_load, dm_run, dm_insn, dm_index, dm_data,
                  res_valid, res_data, res_err, busy};

   // Cycle index: cycle c is the interval that follows the c-th rising edge.
   always @(posedge clk) cyc <= cyc + 1;

   // The engine result is random every cycle; the bench keeps its own copy.
   always @(posedge clk) begin
      #1;
      dm_out = 12'($urandom);
      if (cyc < N) drv_out[cyc] = dm_out;
   end

   // Mid-cycle snapshot of every output.
   always @(negedge clk) begin
      if (cyc < N) obs[cyc] = live;
   end

   // Drives one whole job open-loop and compares every cycle against the expected timeline.
   task automatic run_job(input string name, input logic [1:0] raw, input int nb,
                          input int gmin, input int gmax, input int d);
      int          s, al, fin, kb, lk;
      int          acc[$];
      logic [3:0]  bidx[$];
      logic [3:0]  bdat[$];
      logic [1:0]  mm, ii;
      logic [28:0] e, m, o;
      logic        rv;
      s = cyc;
      acc.push_back(s + 3);
      for (int k = 1; k < nb; k++) acc.push_back(acc[k-1] + $urandom_range(gmax, gmin) + 1);
      for (int k = 0; k < nb; k++) begin
         bidx.push_back(4'($urandom));
         bdat.push_back(4'($urandom));
      end
      al  = acc[nb-1];
      fin = al + R + 4 + d;
      if (fin >= N) begin
         failures++;
         $display("FAIL %s: trace window %0d exceeds %0d", name, fin, N);
         return;
      end
      for (int c = s; c <= fin; c++) begin
         kb = -1;
         if (c <= acc[0]) kb = 0;
         else for (int j = 1; j < nb; j++) if (c == acc[j]) kb = j;
         if (kb >= 0) begin
            cmd_valid = 1'b1;
            cmd_mode  = (kb == 0) ? raw : 2'($urandom);
            cmd_index = bidx[kb];
            cmd_data  = bdat[kb];
            cmd_last  = (kb == nb - 1);
         end else begin
            cmd_valid = 1'b0;
            cmd_mode  = 2'($urandom);
            cmd_index = 4'($urandom);
            cmd_data  = 4'($urandom);
            cmd_last  = 1'($urandom);
         end
         if (c == al + R + 3 + d)                  res_ready = 1'b1;
         else if (c >= al + R + 3 && c < al + R + 3 + d) res_ready = 1'b0;
         else                                      res_ready = 1'($urandom);
         @(posedge clk); #1;
      end
      cmd_valid = 1'b0;
      res_ready = 1'b0;

      mm = (raw == 2'b11) ? 2'b00 : raw;
      ii = (mm == 2'b00) ? 2'b00 : 2'b01;
      for (int c = s + 1; c <= fin; c++) begin
         lk = -1;
         for (int j = 0; j < nb; j++) if (c == acc[j] + 1) lk = j;
         e = '0;
         m = '1;
         e[28] = (c >= s + 3 && c <= al);
         e[27] = (c != s + 1);
         e[26] = (lk >= 0);
         e[25] = (c >= al + 2 && c <= al + 1 + R);
         e[24:23] = (e[26] || e[25]) ? mm : ii;
         if (c == s + 1) m[24:23] = 2'b00;
         if (lk >= 0) begin
            e[22:19] = bidx[lk];
            e[18:15] = bdat[lk];
         end else begin
            m[22:15] = '0;
         end
         rv = (c >= al + R + 3 && c <= al + R + 3 + d);
         e[14] = rv;
         if (rv) begin
            e[13:2] = drv_out[al + R + 2];
            e[1]    = (raw == 2'b11);
         end else begin
            m[13:1] = '0;
         end
         e[0] = (c <= al + R + 3 + d);
         o = obs[c];
         checks++;
         if ((o & m) !== (e & m)) begin
            failures++;
            $display("FAIL %s cycle+%0d: got %h expected %h (mask %h)", name, c - s, o & m, e & m, m);
         end
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      cmd_valid = 1'b0; cmd_mode = 2'b00; cmd_index = 4'd0; cmd_data = 4'd0;
      cmd_last = 1'b0; res_ready = 1'b0;
      @(posedge clk); #1;
      checks++;
      if (live !== 29'h0) begin
         failures++;
         $display("FAIL reset_state: got %h expected %h", live, 29'h0);
      end
      @(posedge clk); #1;
      rst = 1'b0;
      #1;
      checks++;
      if (dm_rst_n !== 1'b0) begin
         failures++;
         $display("FAIL reset_release_hold: dm_rst_n got %b expected 0", dm_rst_n);
      end
      @(posedge clk); #1;
      checks++;
      if (live !== 29'h8000000) begin
         failures++;
         $display("FAIL reset_first_edge: got %h expected %h", live, 29'h8000000);
      end
   endtask

   task automatic test_max_single();
      run_job("max_single", 2'b01, 1, 0, 0, 0);
   endtask

   task automatic test_madd_back_to_back();
      run_job("madd_b2b", 2'b10, 2, 0, 0, 1);
      run_job("madd_b2b_long", 2'b10, 5, 0, 0, 0);
   endtask

   task automatic test_gaps();
      run_job("gaps_min", 2'b00, 4, 1, 3, 2);
      run_job("gaps_madd", 2'b10, 3, 2, 4, 0);
   endtask

   task automatic test_illegal_mode();
      run_job("illegal_mode", 2'b11, 3, 0, 1, 2);
      run_job("after_illegal", 2'b01, 2, 0, 0, 0);
   endtask

   task automatic test_result_stall();
      run_job("result_stall", 2'b10, 2, 0, 1, 10);
   endtask

   task automatic test_reset_mid_run();
      cmd_valid = 1'b1; cmd_mode = 2'b01; cmd_index = 4'd9; cmd_data = 4'd6; cmd_last = 1'b1;
      repeat (4) begin @(posedge clk); #1; end
      cmd_valid = 1'b0;
      repeat (6) begin @(posedge clk); #1; end
      checks++;
      if (dm_run !== 1'b1) begin
         failures++;
         $display("FAIL mid_run_running: dm_run got %b expected 1", dm_run);
      end
      #2;
      rst = 1'b1;
      #1;
      checks++;
      if (live !== 29'h0) begin
         failures++;
         $display("FAIL mid_run_async_reset: got %h expected %h", live, 29'h0);
      end
      @(posedge clk); #1;
      rst = 1'b0;
      @(posedge clk); #1;
      checks++;
      if (live !== 29'h8000000) begin
         failures++;
         $display("FAIL mid_run_after_reset: got %h expected %h", live, 29'h8000000);
      end
      run_job("after_mid_reset", 2'b10, 3, 0, 2, 3);
   endtask

   task automatic test_random_jobs();
      for (int j = 0; j < 20; j++) begin
         run_job($sformatf("random_%0d", j), 2'($urandom), $urandom_range(5, 1), 0,
                 $urandom_range(3, 0), $urandom_range(6, 0));
         repeat ($urandom_range(3, 0)) begin @(posedge clk); #1; end
      end
   endtask

   initial begin
      test_reset();
      test_max_single();
      test_madd_back_to_back();
      test_gaps();
      test_illegal_mode();
      test_result_stall();
      test_reset_mid_run();
      test_random_jobs();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
